display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the BCD-to-7-segment decoder that drives the multi-digit charge/coin display.
//  - Holds a frame of BCD digits and presents one digit per scan slot on the decoder inputs (data/LT/RBI/BI).
//  - Drives the matching one-hot digit enable.
//  - Generates leading-zero suppression and anti-ghosting blanking, so the shared decoder serves all digits.

---
 rtl/display_pkg.sv | 15 +
 rtl/scan_tick_gen.sv | 32 +++
 rtl/display_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types for the BCD display scan path: digit width, decoder control bundle.
// Build option DISPLAY_SCAN_BLINK_EN is consumed by display_scan_ctrl, not here.
package display_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = '0;

    typedef struct packed {
        logic [DIGIT_W-1:0] data;
        logic               lt;
        logic               rbi;
        logic               bi;
    } dec_ctrl_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot timer for scanned peripherals: free-running 0..SLOT_CYCLES-1 counter.
// slot_start/slot_last/guard_active describe the cycle about to be presented at the next edge.
module scan_tick_gen #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_start,
    output logic slot_last,
    output logic guard_active
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (slot_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign slot_start   = (r_cnt == '0);
    assign slot_last    = (r_cnt == CNT_W'(SLOT_CYCLES - 1));
    assign guard_active = (r_cnt < CNT_W'(GUARD_CYCLES));

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed BCD-to-7-seg scan controller: frame double-buffering, leading-zero and guard blanking.
// Define DISPLAY_SCAN_BLINK_EN to add the blink_mask port and the per-frame blink phase counter.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 4,
    parameter int BLINK_SLOTS  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic                          load,
    input  logic                          lamp_test,
    input  logic                          blank,
    input  logic                          lz_en,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
    output logic [DIGIT_W-1:0]            dec_data,
    output logic                          dec_lt,
    output logic                          dec_rbi,
    output logic                          dec_bi,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] MSD_IDX = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || BLINK_SLOTS < 1 ||
        SLOT_CYCLES < GUARD_CYCLES + 2) begin : g_bad_param
        $error("display_scan_ctrl: parameter out of range");
    end

    logic                          w_slot_start;
    logic                          w_slot_last;
    logic                          w_guard;
    logic                          w_frame_start;
    logic [DIGIT_W*NUM_DIGITS-1:0] w_frame;
    logic [DIGIT_W-1:0]            w_digit;
    logic                          w_zrun;
    logic                          w_blink_dark;
    dec_ctrl_t                     w_dec;

    logic [IDX_W-1:0]              r_idx;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_pending;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_active;
    logic                          r_zrun;

    scan_tick_gen #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .slot_start   (w_slot_start),
        .slot_last    (w_slot_last),
        .guard_active (w_guard)
    );

    // The MSD slot edge shows the freshly promoted frame, so read pending directly there.
    assign w_frame_start = w_slot_start && (r_idx == MSD_IDX);
    assign w_frame       = w_frame_start ? r_pending : r_active;
    assign w_digit       = w_frame[r_idx*DIGIT_W +: DIGIT_W];

    // zrun covers the current digit too, so a nonzero digit never carries rbi.
    always_comb begin
        w_zrun = r_zrun;
        if (w_slot_start) begin
            w_zrun = ((r_idx == MSD_IDX) || r_zrun) && (w_digit == DIGIT_ZERO);
        end
    end

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int BCNT_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    logic [BCNT_W-1:0] r_blink_cnt;
    logic              r_blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_slot_last && (r_idx == '0)) begin
            if (r_blink_cnt == BCNT_W'(BLINK_SLOTS - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BCNT_W'(1);
            end
        end
    end

    assign w_blink_dark = r_blink_phase && blink_mask[r_idx];
`else
    assign w_blink_dark = 1'b0;
`endif

    always_comb begin
        w_dec      = '0;
        w_dec.data = w_digit;
        if (blank) begin
            w_dec.bi = 1'b1;
        end else if (lamp_test) begin
            w_dec.lt = 1'b1;
            w_dec.bi = w_guard;
        end else begin
            w_dec.rbi = lz_en && w_zrun && (r_idx != '0);
            w_dec.bi  = w_guard || w_blink_dark;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_data   <= DIGIT_ZERO;
            dec_lt     <= 1'b0;
            dec_rbi    <= 1'b0;
            dec_bi     <= 1'b1;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
            r_pending  <= '0;
            r_active   <= '0;
            r_idx      <= MSD_IDX;
            r_zrun     <= 1'b1;
        end else begin
            dec_data   <= w_dec.data;
            dec_lt     <= w_dec.lt;
            dec_rbi    <= w_dec.rbi;
            dec_bi     <= w_dec.bi;
            digit_sel  <= NUM_DIGITS'(1) << r_idx;
            frame_tick <= w_frame_start;
            r_zrun     <= w_zrun;
            if (load) begin
                r_pending <= value;
            end
            if (w_frame_start) begin
                r_active <= r_pending;
            end
            if (w_slot_last) begin
                r_idx <= (r_idx == '0) ? MSD_IDX : r_idx - IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: position-based reference model plus directed vector table.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int BLINK = 2;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        lamp_test = 1'b0;
    logic        blank = 1'b0;
    logic        lz_en = 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
    logic [3:0]  blink_mask = '0;
`endif
    logic [3:0]  dec_data;
    logic        dec_lt, dec_rbi, dec_bi;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    display_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (SLOT),
        .GUARD_CYCLES (GUARD),
        .BLINK_SLOTS  (BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .lamp_test  (lamp_test),
        .blank      (blank),
        .lz_en      (lz_en),
`ifdef DISPLAY_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .dec_data   (dec_data),
        .dec_lt     (dec_lt),
        .dec_rbi    (dec_rbi),
        .dec_bi     (dec_bi),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          pos = -1;
    logic [15:0] m_pending = '0;
    logic [15:0] m_active = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs for the edge at scan position pos (cycles since the first post-reset edge).
    function automatic logic [11:0] model_out();
        int         s, c, idx, f;
        logic [3:0] d;
        logic       zr, lt, rbi, bi, guard, dark;
        s     = pos / SLOT;
        c     = pos % SLOT;
        idx   = N - 1 - (s % N);
        f     = pos / FRAME;
        d     = m_active[idx*4 +: 4];
        zr    = 1'b1;
        for (int j = N - 1; j >= idx; j--) begin
            if (m_active[j*4 +: 4] != 4'd0) zr = 1'b0;
        end
        guard = (c < GUARD);
        dark  = 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
        dark  = blink_mask[idx] && (((f / BLINK) % 2) == 1);
`endif
        lt = 1'b0; rbi = 1'b0; bi = 1'b0;
        if (blank) begin
            bi = 1'b1;
        end else if (lamp_test) begin
            lt = 1'b1;
            bi = guard;
        end else begin
            rbi = lz_en && zr && (idx != 0);
            bi  = guard || dark;
        end
        return {d, lt, rbi, bi, 4'(1 << idx), 1'((pos % FRAME) == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
        if (pos % FRAME == 0) m_active = m_pending;
        if (load) m_pending = value;
        check($sformatf("cycle@%0d", pos),
              32'({dec_data, dec_lt, dec_rbi, dec_bi, digit_sel, frame_tick}), 32'(model_out()));
    endtask

    task automatic step_to(input int m);
        step();
        while (pos % FRAME != m) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bi", 32'(dec_bi), 32'd1);
        check("rst_sel", 32'(digit_sel), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst_n     = 1'b1;
        pos       = -1;
        m_pending = '0;
        m_active  = '0;
    endtask

    typedef struct {
        logic [15:0] val;
        logic        lz, lamp, blk;
        int          slot, c;
        logic [3:0]  e_data, e_sel;
        logic        e_lt, e_rbi, e_bi;
    } vec_t;

    vec_t tbl[20];
    int   ticks;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{16'h1234, 0, 0, 0, 0, 2, 4'h1, 4'b1000, 0, 0, 0},
            '{16'h1234, 0, 0, 0, 0, 1, 4'h1, 4'b1000, 0, 0, 1},
            '{16'h1234, 0, 0, 0, 1, 2, 4'h2, 4'b0100, 0, 0, 0},
            '{16'h1234, 0, 0, 0, 2, 5, 4'h3, 4'b0010, 0, 0, 0},
            '{16'h1234, 0, 0, 0, 3, 7, 4'h4, 4'b0001, 0, 0, 0},
            '{16'h1234, 0, 0, 0, 3, 0, 4'h4, 4'b0001, 0, 0, 1},
            '{16'h0050, 1, 0, 0, 0, 3, 4'h0, 4'b1000, 0, 1, 0},
            '{16'h0050, 1, 0, 0, 1, 3, 4'h0, 4'b0100, 0, 1, 0},
            '{16'h0050, 1, 0, 0, 2, 3, 4'h5, 4'b0010, 0, 0, 0},
            '{16'h0050, 1, 0, 0, 3, 3, 4'h0, 4'b0001, 0, 0, 0},
            '{16'h0000, 1, 0, 0, 1, 3, 4'h0, 4'b0100, 0, 1, 0},
            '{16'h0000, 1, 0, 0, 2, 3, 4'h0, 4'b0010, 0, 1, 0},
            '{16'h0000, 1, 0, 0, 3, 3, 4'h0, 4'b0001, 0, 0, 0},
            '{16'h0050, 0, 0, 0, 0, 3, 4'h0, 4'b1000, 0, 0, 0},
            '{16'h00A0, 1, 0, 0, 2, 3, 4'hA, 4'b0010, 0, 0, 0},
            '{16'h00A0, 1, 0, 0, 3, 3, 4'h0, 4'b0001, 0, 0, 0},
            '{16'h1234, 0, 1, 1, 1, 4, 4'h2, 4'b0100, 0, 0, 1},
            '{16'h1234, 1, 1, 0, 1, 4, 4'h2, 4'b0100, 1, 0, 0},
            '{16'h1234, 0, 1, 0, 1, 1, 4'h2, 4'b0100, 1, 0, 1},
            '{16'h0000, 1, 0, 1, 0, 3, 4'h0, 4'b1000, 0, 0, 1}
        };

        // Reset and startup: MSD first, one frame_tick per 32 cycles.
        do_reset();
        step();
        check("first_sel", 32'(digit_sel), 32'b1000);
        check("first_tick", 32'(frame_tick), 32'd1);
        ticks = 1;
        repeat (63) begin
            step();
            if (frame_tick) ticks++;
        end
        check("tick_count", 32'(ticks), 32'd2);

        // Directed vectors: load, wait for the frame that shows it, probe one slot position.
        foreach (tbl[i]) begin
            lz_en     = tbl[i].lz;
            lamp_test = tbl[i].lamp;
            blank     = tbl[i].blk;
            value     = tbl[i].val;
            load      = 1'b1;
            step();
            load      = 1'b0;
            step_to(0);
            repeat (tbl[i].slot * SLOT + tbl[i].c) step();
            check($sformatf("vec%0d", i),
                  32'({dec_data, digit_sel, dec_lt, dec_rbi, dec_bi}),
                  32'({tbl[i].e_data, tbl[i].e_sel, tbl[i].e_lt, tbl[i].e_rbi, tbl[i].e_bi}));
        end
        lz_en = 1'b0; lamp_test = 1'b0; blank = 1'b0;

        // No tearing: mid-frame load waits a frame, a load on the frame edge waits two.
        value = 16'h1234; load = 1'b1; step(); load = 1'b0;
        step_to(0);
        step_to(10);
        value = 16'h9999; load = 1'b1; step(); load = 1'b0;
        step_to(20);
        check("tear_old", 32'(dec_data), 32'h3);
        step_to(31);
        value = 16'h5678; load = 1'b1; step(); load = 1'b0;
        check("tear_edge_tick", 32'(frame_tick), 32'd1);
        check("tear_new", 32'(dec_data), 32'h9);
        step_to(0);
        check("tear_next", 32'(dec_data), 32'h5);
        step_to(8);
        check("tear_next2", 32'(dec_data), 32'h6);

        // Asynchronous reset in the middle of a slot.
        step_to(12);
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'({dec_data, dec_lt, dec_rbi, dec_bi, digit_sel, frame_tick}),
              32'({4'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0}));
        do_reset();
        step();
        check("rst_pending_clr", 32'(dec_data), 32'h0);
        check("rst_restart_msd", 32'(digit_sel), 32'b1000);

`ifdef DISPLAY_SCAN_BLINK_EN
        do_reset();
        blink_mask = 4'b0001;
        for (int f = 0; f < 6; f++) begin
            step_to(19);
            check($sformatf("blink_other_f%0d", f), 32'(dec_bi), 32'd0);
            step_to(27);
            check($sformatf("blink_d0_f%0d", f), 32'(dec_bi), 32'(((f / 2) % 2) == 1));
        end
        lamp_test = 1'b1;
        step_to(27);
        check("blink_lamp_override", 32'(dec_bi), 32'd0);
        lamp_test = 1'b0;
`endif

        // Randomised traffic against the reference model.
        for (int k = 0; k < 1500; k++) begin
            value = 16'($urandom);
            load  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 59) == 0) lamp_test = ~lamp_test;
            if ($urandom_range(0, 59) == 0) blank = ~blank;
`ifdef DISPLAY_SCAN_BLINK_EN
            if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
`endif
            step();
        end
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
